mips_mc_core: RTL and testbench
===============================

// Module: mips_mc_core
// PURPOSE
//  Parametrised multicycle core: FSM controller plus datapath in one block; successor to the fixed 32-bit core.
//  Generalised data width, register count and memory depths; adds runtime program load, debug reg read,
//  illegal-opcode trap and retired-instruction counter. Sits at top level under the SoC test shell.
// PARAMETERS
//  DW          32  datapath/register width, >=16; immediates sign-extended from 16 to DW
//  NREGS       32  register count, power of 2, 2..32; reg index = low $clog2(NREGS) bits of field
//  IMEM_DEPTH  16  instruction words (32b), power of 2; IAW=$clog2(IMEM_DEPTH)
//  DMEM_DEPTH  32  data words (DW), power of 2; DAW=$clog2(DMEM_DEPTH)
// PORTS
//  clk         in   1       clock, all state on posedge
//  resetn      in   1       synchronous, active-low reset
//  imem_we     in   1       program load write strobe
//  imem_waddr  in   IAW     program load address
//  imem_wdata  in   32      program load data
//  dbg_raddr   in   RAW     debug register index (RAW=$clog2(NREGS))
//  dbg_rdata   out  DW      combinational read of R[dbg_raddr]
//  pc          out  IAW     current PC
//  halted      out  1       core in HALT
//  illegal     out  1       HALT entered via undefined opcode
//  retired     out  32      completed instructions (EXIT/illegal not counted), wraps 2^32-1 -> 0
// BEHAVIOUR
//  Fields: op=[31:26] rs=[25:21] rt=[20:16] rd=[15:11] imm=[15:0]. Opcodes: ADD 000001 SUB 000010
//   AND 000100 OR 001000 (rd<=rs op rt); LDR 100001 rt<=D[rs+imm]; STR 100010 D[rs+imm]<=rt;
//   LDRI 100100 rt<=sext(imm); JEQ 111110/JNE 111101 PC<=imm[IAW-1:0] if rs==rt / rs!=rt; EXIT 111111.
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT (reset state FETCH).
//   FETCH : IR<=I[PC]; PC<=PC+1 mod IMEM_DEPTH -> DECODE
//   DECODE: A<=R[rs], B<=R[rt]; EXIT->HALT; undefined op->HALT, illegal<=1; LDRI->WB; else->EXEC
//   EXEC  : ALU: Y<=A op B ->WB; LDR/STR: Y<=A+sext(imm) ->MEM; JEQ/JNE: branch resolve ->FETCH
//   MEM   : LDR: M<=D[Y[DAW-1:0]] ->WB; STR: D[Y[DAW-1:0]]<=B ->FETCH
//   WB    : R[dest]<=ALU?Y : LDR?M : sext(imm); ->FETCH
//   HALT  : sticky until reset; no reg/mem/PC updates
//  Latency (cycles, FETCH entry to next FETCH): ALU 4, LDR 5, STR 4, LDRI 3, JEQ/JNE 3; EXIT/illegal 2 to HALT.
//  retired increments in the cycle leaving WB, MEM(STR) or EXEC(branch).
//  Arithmetic mod 2^DW, no flags; addresses/targets truncate (wrap) to DAW/IAW bits.
//  Branch target absolute; taken branch overrides the PC+1 from FETCH.
//  Reset: pc=0, halted=0, illegal=0, retired=0, state FETCH; regs, IR, I/D memories not reset.
//  Reset mid-instruction aborts it: no reg/mem write in the reset cycle.
//  imem_we honoured in any state, also during reset; same-cycle FETCH of same address gets old word.
//  dbg_rdata shows pre-write value during a WB to the same register.
// CONFIGURATION
//  MC_R0_ZERO_EN defined: R0 reads 0 (datapath and dbg), writes to R0 discarded (still retired).
//  Not defined: R0 ordinary general-purpose register.
// TESTING
//  Load {LDRI r0,10; LDRI r1,4; ADD r2,r0,r1; EXIT}, release reset -> halted=1 after 12 edges, R2=14, retired=3, illegal=0
//  LDRI r3,-1 (imm FFFF), DW=32 -> R3=32'hFFFF_FFFF; DW=16 build -> R3=16'hFFFF
//  STR r1 to [r0+2] then LDR r5,[r0+2] (r0=30, DMEM_DEPTH=32) -> D[0]=r1 (wrap), R5=r1, LDR 5 cycles
//  JEQ r0,r0,6 -> pc=6 next FETCH; JNE r0,r0,6 -> pc=PC+1; both 3 cycles
//  Opcode 6'b010101 -> halted=1, illegal=1, retired unchanged; reset then re-run clears both
//  MC_R0_ZERO_EN: LDRI r0,7 -> dbg R0=0; without macro -> dbg R0=7; reset asserted in WB -> target reg unchanged

Source files
------------

// File: rtl/mips_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_core
// Brief    : Parametrised multicycle core (FSM + datapath), with program load,
//            debug register read, illegal-opcode trap and retired counter.
//            Optional MC_R0_ZERO_EN: R0 hard-wired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_core #(
    parameter  int DW         = 32,
    parameter  int NREGS      = 32,
    parameter  int IMEM_DEPTH = 16,
    parameter  int DMEM_DEPTH = 32,
    localparam int IAW        = $clog2(IMEM_DEPTH),
    localparam int DAW        = $clog2(DMEM_DEPTH),
    localparam int RAW        = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           imem_we,
    input  logic [IAW-1:0] imem_waddr,
    input  logic [31:0]    imem_wdata,
    input  logic [RAW-1:0] dbg_raddr,
    output logic [DW-1:0]  dbg_rdata,
    output logic [IAW-1:0] pc,
    output logic           halted,
    output logic           illegal,
    output logic [31:0]    retired
);

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b001000;
    localparam logic [5:0] OP_LDR  = 6'b100001;
    localparam logic [5:0] OP_STR  = 6'b100010;
    localparam logic [5:0] OP_LDRI = 6'b100100;
    localparam logic [5:0] OP_JNE  = 6'b111101;
    localparam logic [5:0] OP_JEQ  = 6'b111110;
    localparam logic [5:0] OP_EXIT = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    logic [31:0]    imem_q [IMEM_DEPTH];
    logic [DW-1:0]  dmem_q [DMEM_DEPTH];
    logic [DW-1:0]  regs_q [NREGS];

    state_t         state_q, state_d;
    logic [IAW-1:0] pc_q, pc_d;
    logic [31:0]    ir_q, ir_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d, y_q, y_d, m_q, m_d;
    logic           illegal_q, illegal_d;
    logic [31:0]    retired_q, retired_d;

    logic           rf_we, dm_we;
    logic [RAW-1:0] rf_waddr;
    logic [DW-1:0]  rf_wdata;

    logic [5:0]     op;
    logic [RAW-1:0] rs_idx, rt_idx, rd_idx;
    logic [DW-1:0]  imm_sx;
    logic           is_alu;

    function automatic logic [DW-1:0] rd_reg(input logic [RAW-1:0] idx);
`ifdef MC_R0_ZERO_EN
        rd_reg = (idx == '0) ? '0 : regs_q[idx];
`else
        rd_reg = regs_q[idx];
`endif
    endfunction

    assign op     = ir_q[31:26];
    assign rs_idx = ir_q[21 +: RAW];
    assign rt_idx = ir_q[16 +: RAW];
    assign rd_idx = ir_q[11 +: RAW];
    assign imm_sx = DW'($signed(ir_q[15:0]));
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        y_d       = y_q;
        m_d       = m_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        rf_we     = 1'b0;
        rf_waddr  = rt_idx;
        rf_wdata  = imm_sx;
        dm_we     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = imem_q[pc_q];
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d = rd_reg(rs_idx);
                b_d = rd_reg(rt_idx);
                case (op)
                    OP_EXIT: state_d = S_HALT;
                    OP_LDRI: state_d = S_WB;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_LDR, OP_STR, OP_JEQ, OP_JNE: state_d = S_EXEC;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (op)
                    OP_ADD: begin y_d = a_q + b_q; state_d = S_WB; end
                    OP_SUB: begin y_d = a_q - b_q; state_d = S_WB; end
                    OP_AND: begin y_d = a_q & b_q; state_d = S_WB; end
                    OP_OR:  begin y_d = a_q | b_q; state_d = S_WB; end
                    OP_LDR, OP_STR: begin
                        y_d     = a_q + imm_sx;
                        state_d = S_MEM;
                    end
                    OP_JEQ, OP_JNE: begin
                        // Taken branch replaces the PC+1 computed in FETCH.
                        if ((op == OP_JEQ) ? (a_q == b_q) : (a_q != b_q))
                            pc_d = ir_q[IAW-1:0];
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (op == OP_LDR) begin
                    m_d     = dmem_q[y_q[DAW-1:0]];
                    state_d = S_WB;
                end else begin
                    dm_we     = 1'b1;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_waddr  = is_alu ? rd_idx : rt_idx;
                rf_wdata  = is_alu ? y_q : (op == OP_LDR) ? m_q : imm_sx;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
        ir_q <= ir_d;
        a_q  <= a_d;
        b_q  <= b_d;
        y_q  <= y_d;
        m_q  <= m_d;
    end

    // Storage writes are suppressed during reset so an aborted instruction leaves no trace.
    always_ff @(posedge clk) begin
        if (imem_we)
            imem_q[imem_waddr] <= imem_wdata;
        if (resetn && dm_we)
            dmem_q[y_q[DAW-1:0]] <= b_q;
`ifdef MC_R0_ZERO_EN
        if (resetn && rf_we && (rf_waddr != '0))
            regs_q[rf_waddr] <= rf_wdata;
`else
        if (resetn && rf_we)
            regs_q[rf_waddr] <= rf_wdata;
`endif
    end

    assign dbg_rdata = rd_reg(dbg_raddr);
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_core
// Brief    : Directed program table plus hand sequences for mips_mc_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_core;

    localparam int NV = 12;
    localparam int NP = 16;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b001000;
    localparam logic [5:0] OP_LDR  = 6'b100001;
    localparam logic [5:0] OP_STR  = 6'b100010;
    localparam logic [5:0] OP_LDRI = 6'b100100;
    localparam logic [5:0] OP_JNE  = 6'b111101;
    localparam logic [5:0] OP_JEQ  = 6'b111110;
    localparam logic [31:0] W_EXIT = {6'b111111, 26'd0};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;
    logic [3:0]  pc;
    logic        halted, illegal;
    logic [31:0] retired;

    mips_mc_core dut (
        .clk(clk), .resetn(resetn), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .pc(pc), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  chk_reg;
        logic [31:0] chk_val;
        int          cycles;
        logic [31:0] ret;
        logic        ill;
    } vec_t;

    vec_t        vecs  [NV];
    logic [31:0] progs [NP][8];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] enc_r(logic [5:0] o, int rs, int rt, int rd);
        enc_r = {o, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] o, int rs, int rt, logic [15:0] imm);
        enc_i = {o, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic load_prog(input int idx);
        @(negedge clk);
        resetn = 1'b0;
        for (int k = 0; k < 16; k++) begin
            imem_we    = 1'b1;
            imem_waddr = 4'(k);
            imem_wdata = (k < 8) ? progs[idx][k] : W_EXIT;
            @(negedge clk);
        end
        imem_we = 1'b0;
    endtask

    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (halted) break;
        end
    endtask

    initial begin
        int n;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 8; k++)
                progs[p][k] = W_EXIT;

        progs[0][0] = enc_i(OP_LDRI, 0, 0, 16'd10);
        progs[0][1] = enc_i(OP_LDRI, 0, 1, 16'd4);
        progs[0][2] = enc_r(OP_ADD, 0, 1, 2);
        vecs[0] = '{5'd2, 32'd14, 12, 32'd3, 1'b0};

        progs[1][0] = enc_i(OP_LDRI, 0, 3, 16'hFFFF);
        vecs[1] = '{5'd3, 32'hFFFF_FFFF, 5, 32'd1, 1'b0};

        progs[2][0] = enc_i(OP_LDRI, 0, 10, 16'd30);
        progs[2][1] = enc_i(OP_LDRI, 0, 1, 16'h0055);
        progs[2][2] = enc_i(OP_STR, 10, 1, 16'd2);
        progs[2][3] = enc_i(OP_LDR, 10, 5, 16'd2);
        vecs[2] = '{5'd5, 32'h55, 17, 32'd4, 1'b0};

        // Address 30+2 wraps to D[0], written by the previous program.
        progs[3][0] = enc_i(OP_LDRI, 0, 7, 16'd0);
        progs[3][1] = enc_i(OP_LDR, 7, 6, 16'd0);
        vecs[3] = '{5'd6, 32'h55, 10, 32'd2, 1'b0};

        for (int v = 4; v <= 6; v++) begin
            progs[v][0] = enc_i(OP_LDRI, 0, 1, 16'h00F0);
            progs[v][1] = enc_i(OP_LDRI, 0, 2, 16'h0F3C);
        end
        progs[4][2] = enc_r(OP_SUB, 1, 2, 3);
        progs[5][2] = enc_r(OP_AND, 1, 2, 3);
        progs[6][2] = enc_r(OP_OR, 1, 2, 3);
        vecs[4] = '{5'd3, 32'hFFFF_F1B4, 12, 32'd3, 1'b0};
        vecs[5] = '{5'd3, 32'h0000_0030, 12, 32'd3, 1'b0};
        vecs[6] = '{5'd3, 32'h0000_0FFC, 12, 32'd3, 1'b0};

        progs[7][0] = enc_i(OP_LDRI, 0, 1, 16'd1);
        progs[7][1] = enc_i(OP_JEQ, 1, 1, 16'd4);
        progs[7][2] = enc_i(OP_LDRI, 0, 2, 16'h0BAD);
        progs[7][4] = enc_i(OP_LDRI, 0, 2, 16'h0077);
        vecs[7] = '{5'd2, 32'h77, 11, 32'd3, 1'b0};

        progs[8][0] = enc_i(OP_LDRI, 0, 1, 16'd1);
        progs[8][1] = enc_i(OP_JNE, 1, 1, 16'd4);
        progs[8][2] = enc_i(OP_LDRI, 0, 2, 16'h0123);
        progs[8][4] = enc_i(OP_LDRI, 0, 2, 16'h0BAD);
        vecs[8] = '{5'd2, 32'h123, 11, 32'd3, 1'b0};

        progs[9][0] = enc_i(OP_LDRI, 0, 4, 16'd9);
        progs[9][1] = {6'b010101, 26'd0};
        progs[9][2] = enc_i(OP_LDRI, 0, 4, 16'd1);
        vecs[9] = '{5'd4, 32'd9, 5, 32'd1, 1'b1};

        progs[10][0] = enc_i(OP_LDRI, 0, 0, 16'd7);
`ifdef MC_R0_ZERO_EN
        vecs[10] = '{5'd0, 32'd0, 5, 32'd1, 1'b0};
`else
        vecs[10] = '{5'd0, 32'd7, 5, 32'd1, 1'b0};
`endif

        progs[11][0] = enc_i(OP_LDRI, 0, 1, 16'hFFFF);
        progs[11][1] = enc_i(OP_LDRI, 0, 2, 16'd1);
        progs[11][2] = enc_r(OP_ADD, 1, 2, 3);
        vecs[11] = '{5'd3, 32'd0, 12, 32'd3, 1'b0};

        progs[12][0] = enc_i(OP_LDRI, 0, 1, 16'd1);
        progs[12][1] = enc_i(OP_JEQ, 1, 1, 16'd6);
        progs[13][0] = enc_i(OP_LDRI, 0, 8, 16'h0011);
        progs[14][0] = enc_i(OP_LDRI, 0, 8, 16'h0022);
        progs[15][0] = enc_i(OP_LDRI, 0, 9, 16'h0001);

        for (int v = 0; v < NV; v++) begin
            load_prog(v);
            check($sformatf("v%0d reset pc", v), 32'(pc), 32'd0);
            check($sformatf("v%0d reset halted", v), 32'(halted), 32'd0);
            check($sformatf("v%0d reset illegal", v), 32'(illegal), 32'd0);
            check($sformatf("v%0d reset retired", v), retired, 32'd0);
            resetn = 1'b1;
            run_to_halt(n);
            check($sformatf("v%0d halted", v), 32'(halted), 32'd1);
            check($sformatf("v%0d cycles", v), 32'(n), 32'(vecs[v].cycles));
            check($sformatf("v%0d retired", v), retired, vecs[v].ret);
            check($sformatf("v%0d illegal", v), 32'(illegal), 32'(vecs[v].ill));
            dbg_raddr = vecs[v].chk_reg;
            #1;
            check($sformatf("v%0d reg", v), dbg_rdata, vecs[v].chk_val);
        end

        // Taken branch: PC+1 from FETCH is replaced by the absolute target.
        load_prog(12);
        resetn = 1'b1;
        edges(4);
        check("jeq pc after fetch", 32'(pc), 32'd2);
        edges(2);
        check("jeq pc target", 32'(pc), 32'd6);

        // Reset asserted while in WB aborts the register write.
        load_prog(13);
        resetn = 1'b1;
        run_to_halt(n);
        load_prog(14);
        resetn = 1'b1;
        dbg_raddr = 5'd8;
        edges(2);
        check("wb prewrite dbg", dbg_rdata, 32'h11);
        @(negedge clk);
        resetn = 1'b0;
        edges(1);
        check("wb reset abort reg", dbg_rdata, 32'h11);
        check("wb reset retired", retired, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        edges(3);
        check("wb rerun reg", dbg_rdata, 32'h22);
        check("wb rerun retired", retired, 32'd1);

        // Program write to the address being fetched: FETCH sees the old word.
        load_prog(15);
        resetn     = 1'b1;
        imem_we    = 1'b1;
        imem_waddr = 4'd0;
        imem_wdata = enc_i(OP_LDRI, 0, 9, 16'h0002);
        dbg_raddr  = 5'd9;
        @(negedge clk);
        imem_we = 1'b0;
        edges(2);
        check("imem same-cycle old word", dbg_rdata, 32'h1);
        @(negedge clk);
        resetn = 1'b0;
        edges(2);
        @(negedge clk);
        resetn = 1'b1;
        edges(3);
        check("imem new word", dbg_rdata, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
